// File: rtl/aramsey118_freq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aramsey118_freq_gen_pkg
// Description : Shared bin constants for the frequency counter / generator.
// Revision    : 1.0 - initial release
// ============================================================================
package aramsey118_freq_gen_pkg;

  localparam int ACC_MOD   = 20;
  localparam int DIGIT_MAX = 9;
  localparam int DIGIT_W   = 4;
  localparam int ACC_W     = 5;
  localparam int SUM_W     = 6;
  localparam int STEP_W    = DIGIT_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_t;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(DIGIT_MAX)) ? DIGIT_W'(DIGIT_MAX) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aramsey118_freq_gen_phase_acc.sv
`default_nettype none
// ============================================================================
// Module      : phase_acc
// Description : Modulo-20 phase accumulator; toggles o_sig on every wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_acc
  import aramsey118_freq_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [STEP_W-1:0] i_step,
  output logic              o_sig
);

  logic [ACC_W-1:0] r_acc;
  logic             r_sig;
  logic [SUM_W-1:0] w_sum;
  logic             w_wrap;
  logic [ACC_W-1:0] w_acc_nxt;

  // step < ACC_MOD, so at most one wrap per accumulation
  assign w_sum     = SUM_W'(r_acc) + SUM_W'(i_step);
  assign w_wrap    = (w_sum >= SUM_W'(ACC_MOD));
  assign w_acc_nxt = w_wrap ? ACC_W'(w_sum - SUM_W'(ACC_MOD)) : ACC_W'(w_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sig <= 1'b0;
    end else if (!i_en) begin
      r_acc <= '0;
      r_sig <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      if (w_wrap) begin
        r_sig <= ~r_sig;
      end
    end
  end

  assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/seg7.sv
`default_nettype none
// ============================================================================
// Module      : seg7
// Description : BCD digit to seven-segment decoder (bit0 = a .. bit6 = g).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7 (
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_digit)
      4'd0:    o_seg = 7'b0111111;
      4'd1:    o_seg = 7'b0000110;
      4'd2:    o_seg = 7'b1011011;
      4'd3:    o_seg = 7'b1001111;
      4'd4:    o_seg = 7'b1100110;
      4'd5:    o_seg = 7'b1101101;
      4'd6:    o_seg = 7'b1111101;
      4'd7:    o_seg = 7'b0000111;
      4'd8:    o_seg = 7'b1111111;
      4'd9:    o_seg = 7'b1101111;
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/aramsey118_freq_gen.sv
`default_nettype none
// ============================================================================
// Module      : aramsey118_freq_gen
// Description : Toggle-density generator selecting a decade bin 0..9.
// Revision    : 1.0 - initial release
// ============================================================================
module aramsey118_freq_gen
  import aramsey118_freq_gen_pkg::*;
#(
  parameter int SWEEP_CYCLES = 1000
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int CNT_W = $clog2(SWEEP_CYCLES);

  logic               w_clk;
  logic               w_rst;
  logic [DIGIT_W-1:0] r_digit_q;
  logic               r_en_q;
  sweep_state_t       r_state;
  sweep_state_t       w_state_nxt;
  logic [CNT_W-1:0]   r_sweep_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [DIGIT_W-1:0] r_sweep_digit;
  logic [DIGIT_W-1:0] w_sdig_nxt;
  logic [DIGIT_W-1:0] w_act;
  logic [STEP_W-1:0]  w_step;
  logic               w_sig;
  logic [6:0]         w_seg;

  assign w_clk = io_in[0];
  assign w_rst = io_in[1];

  // The sweep state register doubles as the registered sweep pin.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_digit_q <= '0;
      r_en_q    <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      r_digit_q <= clamp_digit(io_in[5:2]);
      r_en_q    <= io_in[6];
      r_state   <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = io_in[7] ? ST_RUN : ST_IDLE;
  end

  always_comb begin
    w_cnt_nxt  = '0;
    w_sdig_nxt = '0;
    case (r_state)
      ST_RUN: begin
        if (r_sweep_cnt == CNT_W'(SWEEP_CYCLES - 1)) begin
          w_cnt_nxt  = '0;
          w_sdig_nxt = (r_sweep_digit == DIGIT_W'(DIGIT_MAX)) ? '0 : r_sweep_digit + 1'b1;
        end else begin
          w_cnt_nxt  = r_sweep_cnt + 1'b1;
          w_sdig_nxt = r_sweep_digit;
        end
      end
      default: begin
        w_cnt_nxt  = '0;
        w_sdig_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_sweep_cnt   <= '0;
      r_sweep_digit <= '0;
    end else begin
      r_sweep_cnt   <= w_cnt_nxt;
      r_sweep_digit <= w_sdig_nxt;
    end
  end

  assign w_act  = (r_state == ST_RUN) ? r_sweep_digit : r_digit_q;
  assign w_step = {w_act, 1'b1};

  phase_acc u_acc (
    .clk    (w_clk),
    .rst    (w_rst),
    .i_en   (r_en_q),
    .i_step (w_step),
    .o_sig  (w_sig)
  );

  seg7 u_seg (
    .i_digit (w_act),
    .o_seg   (w_seg)
  );

  assign io_out = {w_sig, w_seg};

endmodule
`default_nettype wire

// File: tb/tb_aramsey118_freq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_aramsey118_freq_gen
// Description : Self-checking bench for the toggle-density generator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aramsey118_freq_gen;

  localparam int SWEEP_CYCLES = 4;

  typedef struct {
    logic [3:0] digit;
    logic       en;
    int         exp_tog;
    int         exp_seg;
  } vec_t;

  logic       clk = 1'b0;
  logic       r_rst = 1'b1;
  logic [3:0] r_digit = 4'd0;
  logic       r_en = 1'b0;
  logic       r_sweep = 1'b0;
  logic [7:0] w_io_in;
  logic [7:0] io_out;

  int n_pass  = 0;
  int n_total = 0;
  int q_exp[$];
  int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  vec_t vecs[8];

  assign w_io_in = {r_sweep, r_en, r_digit, r_rst, clk};

  aramsey118_freq_gen #(.SWEEP_CYCLES(SWEEP_CYCLES)) u_dut (
    .io_in  (w_io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] d, input logic en, input logic sw);
    r_rst   = 1'b1;
    r_digit = d;
    r_en    = en;
    r_sweep = sw;
    @(negedge clk);
    @(negedge clk);
    r_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tog, prev, e, found, s, m_acc, m_act, m_sig;

    vecs[0] = '{4'd0,  1'b1, 10,  'h3F};
    vecs[1] = '{4'd9,  1'b1, 190, 'h6F};
    vecs[2] = '{4'd4,  1'b1, 90,  'h66};
    vecs[3] = '{4'd12, 1'b1, 190, 'h6F};
    vecs[4] = '{4'd1,  1'b1, 30,  'h06};
    vecs[5] = '{4'd7,  1'b1, 150, 'h07};
    vecs[6] = '{4'd15, 1'b1, 190, 'h6F};
    vecs[7] = '{4'd5,  1'b0, 0,   'h6D};

    // Reset state
    #2;
    chk("reset_sig", int'(io_out[7]), 0);
    chk("reset_seg", int'(io_out[6:0]), 'h3F);

    // Table: 200 accumulations per row after the input registers load
    foreach (vecs[i]) begin
      apply_reset(vecs[i].digit, vecs[i].en, 1'b0);
      q_exp.push_back(vecs[i].exp_seg);
      q_exp.push_back(vecs[i].exp_tog);
      q_exp.push_back(vecs[i].exp_tog % 2);
      tick();
      chk($sformatf("row%0d_seg", i), int'(io_out[6:0]), q_exp.pop_front());
      tog  = 0;
      prev = int'(io_out[7]);
      for (int k = 0; k < 200; k++) begin
        tick();
        if (int'(io_out[7]) != prev) tog++;
        prev = int'(io_out[7]);
      end
      chk($sformatf("row%0d_toggles", i), tog, q_exp.pop_front());
      chk($sformatf("row%0d_final_sig", i), int'(io_out[7]), q_exp.pop_front());
    end

    // Digit 0 from reset release: first rise at edge 21, next change at 41
    apply_reset(4'd0, 1'b1, 1'b0);
    found = 0;
    for (e = 1; e <= 40 && found == 0; e++) begin
      tick();
      if (io_out[7]) found = e;
    end
    chk("d0_first_rise_edge", found, 21);
    found = 0;
    for (e = 22; e <= 60 && found == 0; e++) begin
      tick();
      if (!io_out[7]) found = e;
    end
    chk("d0_second_toggle_edge", found, 41);

    // Display follows pin one edge later
    r_digit = 4'd3;
    #1;
    chk("pin_disp_before_edge", int'(io_out[6:0]), 'h3F);
    tick();
    chk("pin_disp_after_edge", int'(io_out[6:0]), 'h4F);

    // Disable mid-stream with digit 9: 30 accumulations leave acc = 10
    apply_reset(4'd9, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) tick();
    r_en = 1'b0;
    tick();
    chk("dis_acc_edgeA", int'(u_dut.u_acc.r_acc), 10);
    tick();
    chk("dis_sig_edgeA1", int'(io_out[7]), 0);
    chk("dis_acc_edgeA1", int'(u_dut.u_acc.r_acc), 0);
    tick();
    tick();
    r_en    = 1'b1;
    r_digit = 4'd0;
    found = 0;
    for (e = 1; e <= 40 && found == 0; e++) begin
      tick();
      if (e == 1) chk("reen_sig_edge1", int'(io_out[7]), 0);
      if (io_out[7]) found = e;
    end
    chk("reen_first_rise_edge", found, 21);

    // Sweep: reference accumulator driven by the expected digit sequence
    apply_reset(4'd7, 1'b1, 1'b1);
    m_acc = 0;
    m_act = 0;
    m_sig = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k >= 2) begin
        s = m_acc + 2 * m_act + 1;
        if (s >= 20) begin
          m_acc = s - 20;
          m_sig = m_sig ^ 1;
        end else begin
          m_acc = s;
        end
      end
      m_act = ((k - 1) / SWEEP_CYCLES) % 10;
      q_exp.push_back(seg_tab[m_act]);
      q_exp.push_back(m_sig);
      chk($sformatf("sweep_seg_e%0d", k), int'(io_out[6:0]), q_exp.pop_front());
      chk($sformatf("sweep_sig_e%0d", k), int'(io_out[7]), q_exp.pop_front());
    end

    // Asynchronous reset between edges while sig is high
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (io_out[7]) found = 1;
      else tick();
    end
    chk("areset_sig_high_seen", found, 1);
    #3;
    r_rst = 1'b1;
    #1;
    chk("areset_sig", int'(io_out[7]), 0);
    chk("areset_seg", int'(io_out[6:0]), 'h3F);
    chk("areset_acc", int'(u_dut.u_acc.r_acc), 0);
    chk("areset_cnt", int'(u_dut.r_sweep_cnt), 0);
    chk("areset_sdig", int'(u_dut.r_sweep_digit), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aramsey118_freq_gen.md
# aramsey118_freq_gen

Programmable toggle-density generator: the stimulus-side counterpart of the team's frequency counter. It produces a signal whose per-cycle toggle probability falls in the centre of a selected decade bin, so a frequency counter reading that signal displays the selected digit 0–9. The digit comes from input pins or from an internal sweep sequencer. The active digit drives the shared seven-segment decoder, and the generated signal is driven on the top output pin.

## Interface
- `SWEEP_CYCLES`, default 1000 — clock edges spent on each digit in sweep mode; legal range ≥ 2.
- `io_in[0]` (clk)  in  1  — sole clock, rising edge.
- `io_in[1]` (reset)  in  1  — asynchronous, active-high reset.
- `io_in[5:2]` (digit)  in  4  — requested digit. Values above 9 clamp to 9.
- `io_in[6]` (enable)  in  1  — when high, the output toggles; when low, the output is forced to 0.
- `io_in[7]` (sweep)  in  1  — when high, an internal counter supplies the digit instead of `io_in[5:2]`.
- `io_out[6:0]`  out  7  — seven-segment pattern of the active digit. Bit 0 = segment a, bit 6 = segment g, 1 = lit.
- `io_out[7]` (sig)  out  1  — generated toggle signal, driven directly from a flop.

## Operation
- **Input registration.** Every edge, `digit_q` ← min(`io_in[5:2]`, 9), `en_q` ← `io_in[6]`, `sweep_q` ← `io_in[7]`.
- **Active digit.** `act` = `sweep_q` ? `sweep_digit` : `digit_q`.
- **Step size.** `step` = 2·`act` + 1, giving a range of 1..19.
- **Phase accumulator.** `acc` is 5 bits with range 0..19, modulus 20. Use a 6-bit sum `s` = `acc` + `step` (maximum 38).
- **Accumulate and toggle.** Each edge with `en_q`=1:
  - if `s` ≥ 20: `acc` ← `s` − 20 and `sig` ← ~`sig`;
  - otherwise: `acc` ← `s` and `sig` holds.
- **Resulting density.** Toggle density = (2d+1)/20, i.e. 0.05, 0.15, …, 0.95. Each value is the centre of counter bin d.
- **Disable.** Each edge with `en_q`=0: `acc` ← 0 and `sig` ← 0.
- **Sweep sequencer** (states IDLE and RUN, held in the `sweep_q` bit):
  - IDLE (`sweep_q`=0): `sweep_cnt` ← 0 and `sweep_digit` ← 0.
  - RUN (`sweep_q`=1): `sweep_cnt` increments each edge. When `sweep_cnt` = `SWEEP_CYCLES`−1, it resets to 0 and `sweep_digit` advances 0→1→…→9→0.
  - The sweep sequencer runs regardless of `en_q`.
- **Digit change.** A change of `act` takes effect on the next accumulation. `acc` is not cleared, so the phase is continuous and there is no glitch or extra toggle.
- **Display.** The segment output is the combinational decode of `act`.

## Timing
- **Reset values** (asynchronous, immediate on reset rise): `sig`=0, `acc`=0, `digit_q`=0, `en_q`=0, `sweep_q`=0, `sweep_cnt`=0, `sweep_digit`=0. Therefore `io_out[7]`=0 and `io_out[6:0]`=7'b0111111 (digit 0).
- **Reset mid-operation.** All state returns to the reset values within the same cycle. There is no partial toggle.
- **Pin-to-accumulator latency.** Inputs are registered at edge 1. The first accumulation using the new `step` occurs at edge 2.
- **Digit 0 after reset release.** With `io_in[6]`=1 and digit 0 held from reset release, the first `sig` rise occurs at edge 21, and `sig` then toggles every 20 edges.
- **Display latency.** `io_out[6:0]` follows an input digit change 1 edge later in pin mode, and immediately on a `sweep_digit` update in sweep mode.
- **Sweep dwell.** The first sweep advance occurs `SWEEP_CYCLES` edges after `sweep_q` first samples 1.
- **Mode or enable falling.** When enable or sweep falls, the effect appears 1 edge after the flop samples the low value.
- **Simultaneous disable and wrap.** When disable coincides with an accumulator wrap, disable wins: `sig`=0 and `acc`=0.

## Structure
- **Shared package / include.** Holds the constants `ACC_MOD`=20, `DIGIT_MAX`=9 and the digit width of 4. The frequency counter and this block both take their bin definitions from this one source.
- **Existing `seg7`.** Reuse it unchanged for the display.
- **New sub-module.** Create one sub-module, `phase_acc`, containing `acc`, the sum, the wrap logic, the `sig` flop and the disable clear. The top level keeps the input registers and the sweep sequencer.
- **Size.** Total RTL is expected to be about 150–200 lines.

## Test plan
- **Digit 0.** Enable=1, digit=0, sweep=0, run 200 edges after the input registers load → exactly 10 toggles on `sig`, with the first rise at edge 21.
- **Digits 9 and 4.** Digit=9 → 190 toggles per 200 edges. Digit=4 → 90 toggles per 200 edges. Feeding either into the frequency counter with DEPTH=200 → it displays 9 and 4 respectively.
- **Clamp.** Digit pins=12 → behaviour is identical to digit 9, and `io_out[6:0]` shows 9.
- **Disable.**
  - Drop enable mid-stream → `sig`=0 and `acc`=0 two edges after the pin falls.
  - Re-enable with digit 0 → the first toggle comes 20 accumulations later.
- **Sweep.** `SWEEP_CYCLES`=4, sweep=1 → the display steps 0,1,…,9,0 every 4 edges. Toggle counts per window match (2d+1)/20.
- **Asynchronous reset.** Assert reset between clock edges while `sig`=1 in sweep mode → `io_out[7]`=0 and the display shows 0 before the next edge, and all counters are 0.
